// File: rtl/key_pickup_ctrl_if.sv
// Game-side bundle between the key pickup controller and its producers/consumers.
// The game logic (master) drives state, timing and player inputs; the controller (slave) returns progress.
interface key_pickup_if;
  logic [3:0] state;
  logic       frame_tick;
  logic [8:0] player_x;
  logic [8:0] player_y;
  logic       pick;
  logic [1:0] key_find;
  logic       key_got;
  logic       all_found;
  logic [3:0] hold_cnt;

  modport master (
    output state, frame_tick, player_x, player_y, pick,
    input  key_find, key_got, all_found, hold_cnt
  );

  modport slave (
    input  state, frame_tick, player_x, player_y, pick,
    output key_find, key_got, all_found, hold_cnt
  );
endinterface

// File: rtl/key_pickup_ctrl.sv
// Key pickup controller: tracks the player against the current key box during STAGE1,
// collects a key after pick is held with overlap for HOLD_FRAMES frames, and advances key_find.
module key_pickup_ctrl #(
  parameter int HOLD_FRAMES = 8,
  parameter int PLAYER_SIZE = 16,
  parameter int KEY_SIZE    = 20
) (
  input  logic         clk,
  input  logic         rst,
  key_pickup_if.slave  bus
);

  localparam logic [3:0] ST_STAGE1   = 4'd2;
  localparam logic [3:0] ST_SUCCESS1 = 4'd3;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEARCH  = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [9:0] KS = 10'(KEY_SIZE);
  localparam logic [9:0] PS = 10'(PLAYER_SIZE);
  localparam logic [3:0] HF = 4'(HOLD_FRAMES);

  localparam logic [9:0] K0_X = 10'd65;
  localparam logic [9:0] K0_Y = 10'd35;
  localparam logic [9:0] K1_X = 10'd235;
  localparam logic [9:0] K1_Y = 10'd35;
  localparam logic [9:0] K2_X = 10'd235;
  localparam logic [9:0] K2_Y = 10'd205;

  logic [1:0] r_fsm;
  logic [1:0] r_key_find;
  logic       r_key_got;
  logic       r_all_found;
  logic [3:0] r_hold_cnt;

  logic [1:0] w_fsm_next;
  logic [1:0] w_key_find_next;
  logic       w_key_got_next;
  logic [3:0] w_hold_cnt_next;

  logic [9:0] w_kx;
  logic [9:0] w_ky;
  logic [9:0] w_px;
  logic [9:0] w_py;
  logic       w_overlap;
  logic       w_engage;
  logic [3:0] w_hold_inc;

  always_comb begin
    w_kx = K0_X;
    w_ky = K0_Y;
    case (r_key_find)
      2'd1: begin
        w_kx = K1_X;
        w_ky = K1_Y;
      end
      2'd2: begin
        w_kx = K2_X;
        w_ky = K2_Y;
      end
      default: begin
        w_kx = K0_X;
        w_ky = K0_Y;
      end
    endcase
  end

  assign w_px = {1'b0, bus.player_x};
  assign w_py = {1'b0, bus.player_y};

  // 10-bit sums cannot wrap for on-screen coordinates, so the compares are exact.
  assign w_overlap = (r_key_find != 2'd3)
                   && (w_px < w_kx + KS) && (w_px + PS > w_kx)
                   && (w_py < w_ky + KS) && (w_py + PS > w_ky);

  assign w_engage   = bus.pick && w_overlap;
  assign w_hold_inc = r_hold_cnt + 4'd1;

  always_comb begin
    w_fsm_next      = r_fsm;
    w_key_find_next = r_key_find;
    w_key_got_next  = 1'b0;
    w_hold_cnt_next = r_hold_cnt;

    if (bus.state != ST_STAGE1) begin
      // Leaving the stage aborts any hold; only the success screen preserves progress.
      w_fsm_next      = S_IDLE;
      w_hold_cnt_next = 4'd0;
      if (bus.state != ST_SUCCESS1)
        w_key_find_next = 2'd0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          w_fsm_next      = S_SEARCH;
          w_hold_cnt_next = 4'd0;
        end
        S_SEARCH: begin
          w_hold_cnt_next = 4'd0;
          if (w_engage)
            w_fsm_next = S_HOLD;
        end
        S_HOLD: begin
          if (!w_engage) begin
            w_fsm_next      = S_SEARCH;
            w_hold_cnt_next = 4'd0;
          end else if (bus.frame_tick) begin
            if (w_hold_inc == HF) begin
              w_key_find_next = r_key_find + 2'd1;
              w_key_got_next  = 1'b1;
              w_hold_cnt_next = 4'd0;
              w_fsm_next      = S_RELEASE;
            end else begin
              w_hold_cnt_next = w_hold_inc;
            end
          end
        end
        S_RELEASE: begin
          w_hold_cnt_next = 4'd0;
          if (!bus.pick)
            w_fsm_next = S_SEARCH;
        end
        default: begin
          w_fsm_next      = S_IDLE;
          w_hold_cnt_next = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm       <= S_IDLE;
      r_key_find  <= 2'd0;
      r_key_got   <= 1'b0;
      r_all_found <= 1'b0;
      r_hold_cnt  <= 4'd0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_key_find  <= w_key_find_next;
      r_key_got   <= w_key_got_next;
      r_all_found <= (w_key_find_next == 2'd3);
      r_hold_cnt  <= w_hold_cnt_next;
    end
  end

  assign bus.key_find  = r_key_find;
  assign bus.key_got   = r_key_got;
  assign bus.all_found = r_all_found;
  assign bus.hold_cnt  = r_hold_cnt;

endmodule

// File: tb/tb_key_pickup_ctrl.sv
// Directed bench for key_pickup_ctrl: collection sequence, release lockout, overlap edges, aborts and async reset.
module tb_key_pickup_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  key_pickup_if bus ();

  key_pickup_ctrl #(
    .HOLD_FRAMES(8),
    .PLAYER_SIZE(16),
    .KEY_SIZE(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n frame ticks, each followed by an idle cycle; returns how many cycles key_got was seen high.
  task automatic tick_n(input int n, output int got_cnt);
    got_cnt = 0;
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      if (bus.key_got) got_cnt++;
      bus.frame_tick = 1'b0;
      step();
      if (bus.key_got) got_cnt++;
    end
  endtask

  // Release pick for a cycle then press again, landing in HOLD if overlapping.
  task automatic enter_hold();
    bus.pick = 1'b0;
    step();
    bus.pick = 1'b1;
    step();
  endtask

  task automatic place(input int x, input int y);
    bus.player_x = 9'(x);
    bus.player_y = 9'(y);
  endtask

  initial begin
    int g;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.state = 4'd0;
    bus.frame_tick = 1'b0;
    bus.pick = 1'b0;
    place(0, 0);
    step();
    step();
    chk("rst_key_find", 32'(bus.key_find), 0);
    chk("rst_key_got", 32'(bus.key_got), 0);
    chk("rst_all_found", 32'(bus.all_found), 0);
    chk("rst_hold_cnt", 32'(bus.hold_cnt), 0);
    rst = 1'b0;

    // 1: first key
    bus.state = 4'd2;
    place(60, 30);
    bus.pick = 1'b1;
    step();
    step();
    tick_n(7, g);
    chk("t1_hold7", 32'(bus.hold_cnt), 7);
    chk("t1_nogot7", 32'(g), 0);
    tick_n(1, g);
    chk("t1_got_once", 32'(g), 1);
    chk("t1_key_find", 32'(bus.key_find), 1);
    chk("t1_hold_clr", 32'(bus.hold_cnt), 0);

    // 2: held pick over key1 must not collect until re-pressed
    place(230, 30);
    tick_n(20, g);
    chk("t2_release_nogot", 32'(g), 0);
    chk("t2_key_find_stay", 32'(bus.key_find), 1);
    chk("t2_hold_zero", 32'(bus.hold_cnt), 0);
    enter_hold();
    tick_n(8, g);
    chk("t2_got", 32'(g), 1);
    chk("t2_key_find", 32'(bus.key_find), 2);

    // 3: partial hold, then full hold to finish
    place(235, 205);
    enter_hold();
    tick_n(5, g);
    chk("t3_hold5", 32'(bus.hold_cnt), 5);
    bus.pick = 1'b0;
    step();
    chk("t3_drop_hold", 32'(bus.hold_cnt), 0);
    chk("t3_drop_kf", 32'(bus.key_find), 2);
    enter_hold();
    tick_n(8, g);
    chk("t3_got", 32'(g), 1);
    chk("t3_key_find", 32'(bus.key_find), 3);
    chk("t3_all_found", 32'(bus.all_found), 1);
    enter_hold();
    tick_n(10, g);
    chk("t3_sat_nogot", 32'(g), 0);
    chk("t3_sat_hold", 32'(bus.hold_cnt), 0);
    chk("t3_sat_kf", 32'(bus.key_find), 3);

    // 4: no overlap, and the x edge of key0
    bus.pick = 1'b0;
    bus.state = 4'd0;
    step();
    chk("t4_title_kf", 32'(bus.key_find), 0);
    chk("t4_title_all", 32'(bus.all_found), 0);
    bus.state = 4'd2;
    step();
    place(100, 100);
    bus.pick = 1'b1;
    tick_n(20, g);
    chk("t4_far_nogot", 32'(g), 0);
    chk("t4_far_hold", 32'(bus.hold_cnt), 0);
    chk("t4_far_kf", 32'(bus.key_find), 0);
    place(85, 30);
    tick_n(2, g);
    chk("t4_x85_hold", 32'(bus.hold_cnt), 0);
    place(84, 30);
    step();
    tick_n(1, g);
    chk("t4_x84_hold", 32'(bus.hold_cnt), 1);

    // 5: aborts mid-hold
    tick_n(3, g);
    chk("t5_hold4", 32'(bus.hold_cnt), 4);
    bus.state = 4'd8;
    step();
    chk("t5_fail_hold", 32'(bus.hold_cnt), 0);
    chk("t5_fail_kf", 32'(bus.key_find), 0);
    bus.state = 4'd2;
    step();
    place(60, 30);
    enter_hold();
    tick_n(8, g);
    place(235, 35);
    enter_hold();
    tick_n(8, g);
    chk("t5_kf2", 32'(bus.key_find), 2);
    place(235, 205);
    enter_hold();
    tick_n(4, g);
    chk("t5_hold4b", 32'(bus.hold_cnt), 4);
    bus.state = 4'd3;
    step();
    chk("t5_succ_hold", 32'(bus.hold_cnt), 0);
    chk("t5_succ_kf", 32'(bus.key_find), 2);
    tick_n(2, g);
    chk("t5_succ_nogot", 32'(g), 0);

    // 6: async reset between edges while holding
    bus.state = 4'd2;
    step();
    enter_hold();
    tick_n(3, g);
    chk("t6_hold3", 32'(bus.hold_cnt), 3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_kf", 32'(bus.key_find), 0);
    chk("t6_rst_all", 32'(bus.all_found), 0);
    chk("t6_rst_got", 32'(bus.key_got), 0);
    chk("t6_rst_hold", 32'(bus.hold_cnt), 0);
    step();
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/key_pickup_ctrl.md
Name: key_pickup_ctrl

Overview:
- Game-logic producer of the `key_find` progress code that the object renderer consumes.
- During STAGE1 it tracks the player sprite against the current key's on-screen box.
- A key is collected when the player holds the pick input for HOLD_FRAMES frames while overlapping that key; `key_find` then advances.
- It also emits a one-cycle collect pulse for the sound and score blocks, and a done level for door unlock.

Parameters:
- HOLD_FRAMES, 8, frame ticks pick must stay asserted with overlap before collection (1..15)
- PLAYER_SIZE, 16, player sprite width and height in 320x240 pixel units
- KEY_SIZE, 20, key box width and height in 320x240 pixel units

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- state  in  4  game state code (TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8)
- frame_tick  in  1  one-cycle pulse once per video frame
- player_x  in  9  player top-left x, 0..319
- player_y  in  9  player top-left y, 0..239
- pick  in  1  level from keyboard decoder, 1 = pick key held
- key_find  out  2  0 = seeking key1, 1 = seeking key2, 2 = seeking key3, 3 = all found (FIND_DOOR)
- key_got  out  1  one-cycle pulse on each collection
- all_found  out  1  level, high when key_find==3
- hold_cnt  out  4  current hold progress, for a progress-bar overlay

Behaviour:
- Reset (async, rst=1) gives: key_find=0, key_got=0, all_found=0, hold_cnt=0, FSM=IDLE.
- Key boxes (top-left):
  - k0 = (65,35)
  - k1 = (235,35)
  - k2 = (235,205)
  - Each box is KEY_SIZE square; the box selected is indexed by key_find.
- Overlap (combinational, 10-bit unsigned math, no wrap) is true when all four hold:
  - player_x < kx+KEY_SIZE
  - player_x+PLAYER_SIZE > kx
  - player_y < ky+KEY_SIZE
  - player_y+PLAYER_SIZE > ky
- Overlap is forced to 0 when key_find==3.
- FSM states: IDLE, SEARCH, HOLD, RELEASE.
- IDLE:
  - Entered whenever state != STAGE1, from any FSM state, on the next clk; hold_cnt is cleared.
  - key_find is kept while state is SUCCESS1.
  - key_find is cleared to 0 when state is any other value (TITLE, FAIL, etc.).
  - Goes to SEARCH on the clk after state==STAGE1 is seen.
- SEARCH: when pick && overlap -> HOLD with hold_cnt=0.
- HOLD:
  - On frame_tick with pick && overlap, hold_cnt increments.
  - Leaving the condition (pick=0 or overlap=0) on any cycle -> SEARCH, hold_cnt=0.
  - When hold_cnt would reach HOLD_FRAMES, that same clk:
    - key_find += 1
    - key_got = 1 for exactly one cycle
    - hold_cnt = 0
    - FSM -> RELEASE
- RELEASE:
  - Waits for pick=0, then -> SEARCH.
  - A held pick therefore never collects two keys.
- Saturation: key_find never exceeds 3; at key_find==3 the FSM stays in SEARCH/RELEASE and never enters HOLD.
- all_found is registered and equals (key_find==3), updating the same clk as key_find.
- frame_tick and a condition loss in the same cycle: loss wins, no increment.
- Latency: key_got and key_find update on the clk edge of the qualifying frame_tick (1 cycle after the inputs are sampled).
- State leaving STAGE1 mid-HOLD: abort to IDLE next clk, no collection, hold_cnt=0.
- Reset asserted mid-HOLD: all outputs return to reset values immediately.
- key_find is produced only by this block; the renderer treats it as read-only.

Test Plan:
1. Reset, state=2, player=(60,30), pick=1, 8 frame_ticks -> on the 8th tick key_find 0->1, key_got high 1 cycle, hold_cnt back to 0.
2. Continue holding pick=1 at (230,30) over key1 for 20 ticks -> key_find stays 1 (RELEASE); drop pick, reassert, 8 ticks -> key_find=2.
3. Player (235,205), pick=1, drop pick after 5 ticks -> hold_cnt returns 0, key_find=2; repeat holding for 8 ticks -> key_find=3, all_found=1; further pick/ticks -> no key_got.
4. Player (100,100), pick=1, 20 ticks -> no overlap, key_find unchanged, hold_cnt=0; boundary player_x=85 against k0 gives no overlap, player_x=84 gives overlap.
5. Mid-HOLD (hold_cnt=4) set state=8 -> next clk hold_cnt=0, key_find=0; set state=3 from key_find=2 instead -> key_find stays 2.
6. Assert rst asynchronously between clk edges with key_find=2 -> key_find=0, all_found=0, key_got=0 immediately, without waiting for a clk edge.
